// File: rtl/reset_sequencer.sv
// reset_sequencer: staged active-low reset release driven by two PLL lock flags.
// Both lock inputs are synchronised into the 27MHz domain. Once both have been
// stable long enough, SDRAM leaves reset, then the VDP core after the SDRAM
// init window, then the HDMI/audio path after a short gap.
// Optional feature macro: RESET_LOCK_WATCHDOG_EN. When defined, a lock loss in
// RUN restarts the sequence and is counted (saturating at 255). When undefined,
// RUN is terminal until rst_n and lock_loss_count reads zero.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 2700,
  parameter int SDRAM_INIT_CYCLES  = 5400,
  parameter int STAGE_GAP_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_135_lock,
  input  logic       clk_sdram_lock,
  output logic       sdram_rst_n,
  output logic       vdp_rst_n,
  output logic       hdmi_rst_n,
  output logic       ready,
  output logic [1:0] seq_state,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB     = (LOCK_STABLE_CYCLES > SDRAM_INIT_CYCLES) ?
                              LOCK_STABLE_CYCLES : SDRAM_INIT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > STAGE_GAP_CYCLES) ? MAX_AB : STAGE_GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  // The stability counter starts at the first edge that sees locks_ok, so the
  // lock window ends when it has counted a full LOCK_STABLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] SDRAM_TC = CNT_W'(SDRAM_INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    SDRAM_INIT = 2'd1,
    GAP        = 2'd2,
    RUN        = 2'd3
  } state_t;

  logic [1:0]       sync_135_q;
  logic [1:0]       sync_sdram_q;
  logic             locks_ok;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sdram_q, sdram_d;
  logic             vdp_q, vdp_d;
  logic             hdmi_q, hdmi_d;
  logic             ready_q, ready_d;
`ifdef RESET_LOCK_WATCHDOG_EN
  logic [7:0]       loss_q, loss_d;
`endif

  // Two-flop synchronisers for the asynchronous PLL lock flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_135_q   <= 2'b00;
      sync_sdram_q <= 2'b00;
    end else begin
      sync_135_q   <= {sync_135_q[0], clk_135_lock};
      sync_sdram_q <= {sync_sdram_q[0], clk_sdram_lock};
    end
  end

  assign locks_ok = sync_135_q[1] & sync_sdram_q[1];

  // Sequencer state, stage counter and registered reset outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      sdram_q <= 1'b0;
      vdp_q   <= 1'b0;
      hdmi_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdram_q <= sdram_d;
      vdp_q   <= vdp_d;
      hdmi_q  <= hdmi_d;
      ready_q <= ready_d;
    end
  end

`ifdef RESET_LOCK_WATCHDOG_EN
  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end
`endif

  // Next-state logic: each stage advances on its terminal count unless the
  // locks drop, which always wins and returns everything to reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sdram_d = sdram_q;
    vdp_d   = vdp_q;
    hdmi_d  = hdmi_q;
    ready_d = ready_q;
`ifdef RESET_LOCK_WATCHDOG_EN
    loss_d  = loss_q;
`endif
    case (state_q)
      WAIT_LOCK: begin
        if (!locks_ok) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_TC) begin
          state_d = SDRAM_INIT;
          cnt_d   = '0;
          sdram_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SDRAM_INIT: begin
        if (!locks_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          sdram_d = 1'b0;
          vdp_d   = 1'b0;
          hdmi_d  = 1'b0;
          ready_d = 1'b0;
        end else if (cnt_q == SDRAM_TC) begin
          state_d = GAP;
          cnt_d   = '0;
          vdp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (!locks_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          sdram_d = 1'b0;
          vdp_d   = 1'b0;
          hdmi_d  = 1'b0;
          ready_d = 1'b0;
        end else if (cnt_q == GAP_TC) begin
          state_d = RUN;
          cnt_d   = '0;
          hdmi_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
`ifdef RESET_LOCK_WATCHDOG_EN
        if (!locks_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          sdram_d = 1'b0;
          vdp_d   = 1'b0;
          hdmi_d  = 1'b0;
          ready_d = 1'b0;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
`endif
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        sdram_d = 1'b0;
        vdp_d   = 1'b0;
        hdmi_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign sdram_rst_n = sdram_q;
  assign vdp_rst_n   = vdp_q;
  assign hdmi_rst_n  = hdmi_q;
  assign ready       = ready_q;
  assign seq_state   = state_q;
`ifdef RESET_LOCK_WATCHDOG_EN
  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with short stage lengths (8/20/4 cycles).
// Expected output snapshots are queued with the edge number at which they must
// hold; a monitor compares them on the falling edge after that rising edge.
module tb_reset_sequencer;

  localparam int L     = 8;
  localparam int S     = 20;
  localparam int G     = 4;
  localparam int T_SD  = 2 + L;
  localparam int T_VDP = T_SD + S;
  localparam int T_HD  = T_VDP + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock135;
  logic       locksd;
  logic       sdram_rst_n;
  logic       vdp_rst_n;
  logic       hdmi_rst_n;
  logic       ready;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_count;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(L),
    .SDRAM_INIT_CYCLES (S),
    .STAGE_GAP_CYCLES  (G)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_135_lock   (lock135),
    .clk_sdram_lock (locksd),
    .sdram_rst_n    (sdram_rst_n),
    .vdp_rst_n      (vdp_rst_n),
    .hdmi_rst_n     (hdmi_rst_n),
    .ready          (ready),
    .seq_state      (seq_state),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  int edge_n  = -1;
  int n_pass  = 0;
  int n_total = 0;

  always @(posedge clk) edge_n++;

  typedef struct {
    int          cyc;
    logic [13:0] exp;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;

  function automatic logic [13:0] pk(input logic s, input logic v, input logic h,
                                     input logic r, input logic [1:0] st,
                                     input logic [7:0] c);
    return {s, v, h, r, st, c};
  endfunction

  function automatic logic [13:0] obs();
    return {sdram_rst_n, vdp_rst_n, hdmi_rst_n, ready, seq_state, lock_loss_count};
  endfunction

  task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed {s,v,h,rdy,st,cnt}=%b required %b", tag, o, e);
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, o, e);
  endtask

  task automatic push(input int c, input string tag, input logic [13:0] e);
    exp_t x;
    x.cyc = c;
    x.exp = e;
    x.tag = tag;
    sb_q.push_back(x);
  endtask

  // Full release sequence when locks_ok inputs first rise just before edge e0.
  task automatic push_seq(input int e0, input string p, input logic [7:0] c);
    push(e0 + T_SD - 1,  {p, "_pre_sdram"}, pk(0, 0, 0, 0, 2'd0, c));
    push(e0 + T_SD,      {p, "_sdram"},     pk(1, 0, 0, 0, 2'd1, c));
    push(e0 + T_VDP - 1, {p, "_pre_vdp"},   pk(1, 0, 0, 0, 2'd1, c));
    push(e0 + T_VDP,     {p, "_vdp"},       pk(1, 1, 0, 0, 2'd2, c));
    push(e0 + T_HD - 1,  {p, "_pre_hdmi"},  pk(1, 1, 0, 0, 2'd2, c));
    push(e0 + T_HD,      {p, "_run"},       pk(1, 1, 1, 1, 2'd3, c));
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_int("drain_pending", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_int("ready_timeout", int'(ready === 1'b1), 1);
  endtask

  // Scoreboard monitor: compare every expectation due at the latest edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
      mon_x = sb_q.pop_front();
      if (mon_x.cyc == edge_n) chk(mon_x.tag, obs(), mon_x.exp);
      else chk_int({mon_x.tag, "_late"}, edge_n, mon_x.cyc);
    end
  end

  initial begin
    int e0;
    int e1;
    int d;
    int r;

    // Reset held with locks already high: nothing may move.
    rst_n   = 1'b0;
    lock135 = 1'b1;
    locksd  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    chk("reset_state", obs(), 14'h0);

    // Nominal release.
    rst_n = 1'b1;
    e0 = edge_n + 1;
    push_seq(e0, "nom", 8'd0);
    wait_drain(60);
    wait_to(edge_n + 3);
    chk("run_stable", obs(), pk(1, 1, 1, 1, 2'd3, 8'd0));

    // Lock drop while running.
    lock135 = 1'b0;
    e1 = edge_n + 1;
`ifdef RESET_LOCK_WATCHDOG_EN
    push(e1 + 1, "run_predrop", pk(1, 1, 1, 1, 2'd3, 8'd0));
    push(e1 + 2, "wd_drop",     pk(0, 0, 0, 0, 2'd0, 8'd1));
    wait_to(e1);
    lock135 = 1'b1;
    wait_drain(10);
    for (int i = 0; i < 299; i++) begin
      wait_ready(100);
      lock135 = 1'b0;
      d = edge_n + 1;
      if (i == 0)   push(d + 2, "wd_cnt2", pk(0, 0, 0, 0, 2'd0, 8'd2));
      if (i == 298) push(d + 2, "wd_sat",  pk(0, 0, 0, 0, 2'd0, 8'd255));
      wait_to(d);
      lock135 = 1'b1;
      wait_to(d + 2);
    end
    wait_drain(10);
`else
    push(e1 + 2, "nowd_hold",  pk(1, 1, 1, 1, 2'd3, 8'd0));
    push(e1 + 5, "nowd_hold2", pk(1, 1, 1, 1, 2'd3, 8'd0));
    wait_to(e1 + 2);
    lock135 = 1'b1;
    wait_drain(10);
`endif

    // Reset again, then a one-cycle SDRAM lock glitch during the stability window.
    rst_n   = 1'b0;
    lock135 = 1'b0;
    locksd  = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_again", obs(), 14'h0);
    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    lock135 = 1'b1;
    locksd  = 1'b1;
    e0 = edge_n + 1;
    push(e0 + T_SD,     "glitch_norel", pk(0, 0, 0, 0, 2'd0, 8'd0));
    push(e0 + T_SD + 4, "glitch_pre",   pk(0, 0, 0, 0, 2'd0, 8'd0));
    push(e0 + T_SD + 5, "glitch_rel",   pk(1, 0, 0, 0, 2'd1, 8'd0));
    wait_to(e0 + 3);
    locksd = 1'b0;
    wait_to(e0 + 4);
    locksd = 1'b1;

    // 135MHz lock drop during SDRAM_INIT, then relock and full replay.
    wait_to(e0 + 19);
    lock135 = 1'b0;
    d = edge_n + 1;
    push(d + 1, "drop_hold", pk(1, 0, 0, 0, 2'd1, 8'd0));
    push(d + 2, "drop_rst",  pk(0, 0, 0, 0, 2'd0, 8'd0));
    wait_to(d + 2);
    lock135 = 1'b1;
    r = edge_n + 1;
    push_seq(r, "replay", 8'd0);
    wait_drain(60);

    // Asynchronous reset pulse in the middle of GAP.
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    e0 = edge_n + 1;
    wait_to(e0 + T_VDP + 1);
    chk("gap_state", obs(), pk(1, 1, 0, 0, 2'd2, 8'd0));
    rst_n = 1'b0;
    #1;
    chk("async_rst", obs(), 14'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    e0 = edge_n + 1;
    push_seq(e0, "restart", 8'd0);
    wait_drain(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
